// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package md_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MULT,
        MD_DIV,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand, then an
// arithmetic right shift of {acc, q, q_-1}.
module booth_step
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q_m1_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q_m1_o
);

    // acc carries one guard bit so that subtracting a multiplicand of -2^(WIDTH-1) cannot overflow
    logic [WIDTH:0] mcand_ext;
    logic [WIDTH:0] sum;

    assign mcand_ext = {mcand_i[WIDTH-1], mcand_i};

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q_m1_i})
            2'b10:   sum = acc_i - mcand_ext;
            2'b01:   sum = acc_i + mcand_ext;
            default: sum = acc_i;
        endcase
        {acc_o, q_o, q_m1_o} = {sum[WIDTH], sum, q_i};
    end

endmodule

// File: rtl/mult_div_controller.sv
// Sequencer for the shared iterative unit: 32-step Booth signed multiply or restoring signed
// divide, results in hi/lo, one-cycle done pulse.
module mult_div_controller
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             q_m1_q;
    logic [WIDTH-1:0] mcand_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_q;
    logic             booth_q_m1;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_booth_step (
        .acc_i   (acc_q),
        .q_i     (q_q),
        .q_m1_i  (q_m1_q),
        .mcand_i (mcand_q),
        .acc_o   (booth_acc),
        .q_o     (booth_q),
        .q_m1_o  (booth_q_m1)
    );

    // Unsigned magnitudes: -2^(WIDTH-1) maps onto itself, which is the correct unsigned value
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_mag = op_a_i[WIDTH-1] ? -op_a_i : op_a_i;
    assign b_mag = op_b_i[WIDTH-1] ? -op_b_i : op_b_i;

    // Restoring divide step: rem lives in acc_q[WIDTH-1:0], quotient shifts through q_q
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             unused_diff_msb;

    always_comb begin
        rem_sh  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, mcand_q};
        diff    = rem_sh - {1'b0, mcand_q};
        rem_nxt = rem_ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt = {q_q[WIDTH-2:0], rem_ge};
        quo_fix = quo_neg_q ? -quo_nxt : quo_nxt;
        rem_fix = rem_neg_q ? -rem_nxt : rem_nxt;
    end

    assign unused_diff_msb = diff[WIDTH];

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            q_m1_q     <= 1'b0;
            mcand_q    <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            unique case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        cnt_q     <= CNT_W'(WIDTH);
                        acc_q     <= '0;
                        q_m1_q    <= 1'b0;
                        quo_neg_q <= op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
                        rem_neg_q <= op_a_i[WIDTH-1];
                        if (is_div_i == MD_OP_MULT) begin
                            q_q     <= op_b_i;
                            mcand_q <= op_a_i;
                            busy_q  <= 1'b1;
                            state_q <= MD_MULT;
                        end else if (op_b_i == '0) begin
                            // Divide by zero: report immediately, leave hi/lo untouched
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                            state_q    <= MD_DONE;
                        end else begin
                            q_q     <= a_mag;
                            mcand_q <= b_mag;
                            busy_q  <= 1'b1;
                            state_q <= MD_DIV;
                        end
                    end
                end
                MD_MULT: begin
                    acc_q  <= booth_acc;
                    q_q    <= booth_q;
                    q_m1_q <= booth_q_m1;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= booth_acc[WIDTH-1:0];
                        lo_q    <= booth_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= MD_DONE;
                    end
                end
                MD_DIV: begin
                    acc_q <= {1'b0, rem_nxt};
                    q_q   <= quo_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= rem_fix;
                        lo_q    <= quo_fix;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_controller.sv
// Scoreboard bench for mult_div_controller: stimulus queues expected results, a monitor checks
// every done pulse, busy window and hi/lo hold behaviour.
module tb_mult_div_controller;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        is_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          cyc;
    int          checks;
    int          errors;
    exp_t        sb[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          busy_from;
    int          busy_to;

    mult_div_controller dut (
        .clock_i    (clock),
        .reset_ni   (reset_n),
        .start_i    (start),
        .is_div_i   (is_div),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .busy_o     (busy),
        .done_o     (done),
        .div_zero_o (div_zero),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: sampled mid-cycle on the falling edge
    always @(negedge clock) begin
        if (reset_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1, expected done=0", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    model_hi = e.hi;
                    model_lo = e.lo;
                    chk("done_cycle", cyc, e.cyc);
                    chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
                end
            end else begin
                chk("div_zero_idle", {31'b0, div_zero}, 32'h0);
                if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_done at cycle %0d: got done=0, expected done=1", cyc);
                end
            end
            chk("hi", hi, model_hi);
            chk("lo", lo, model_lo);
            chk("busy", {31'b0, busy}, {31'b0, (cyc >= busy_from && cyc <= busy_to)});
        end
    end

    task automatic issue(input logic div, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic dz);
        exp_t e;
        @(posedge clock);
        #1;
        start  = 1'b1;
        is_div = div;
        op_a   = a;
        op_b   = b;
        e.hi   = eh;
        e.lo   = el;
        e.dz   = dz;
        if (dz) begin
            e.cyc     = cyc + 1;
            busy_from = 1;
            busy_to   = 0;
        end else begin
            e.cyc     = cyc + 33;
            busy_from = cyc + 1;
            busy_to   = cyc + 32;
        end
        sb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout at cycle %0d: got no done, expected done within %0d",
                     cyc, budget);
            sb.delete();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_hi  = 32'h0;
        model_lo  = 32'h0;
        busy_from = 1;
        busy_to   = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        is_div    = 1'b0;
        op_a      = 32'h0;
        op_b      = 32'h0;

        #2;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_div_zero", {31'b0, div_zero}, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        #20;
        reset_n = 1'b1;

        issue(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_done(40);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        wait_done(40);
        issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(40);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done(40);
        // 0x451 / 0x20 = 0x22 remainder 0x11
        issue(1'b1, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0);
        wait_done(40);
        issue(1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1);
        wait_done(5);

        // Stray start at cycle 10 must be dropped
        issue(1'b0, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        start  = 1'b1;
        is_div = 1'b1;
        op_a   = 32'h0000_0064;
        op_b   = 32'h0000_0000;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(40);
        issue(1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        wait_done(40);

        // Asynchronous reset in cycle 15 of a divide
        issue(1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);
        repeat (14) @(posedge clock);
        #3;
        reset_n = 1'b0;
        sb.delete();
        busy_from = 1;
        busy_to   = 0;
        model_hi  = 32'h0;
        model_lo  = 32'h0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        issue(1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0);
        wait_done(40);

        repeat (3) @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
